axi_nap_csr_master_ext: RTL and testbench

//  Parametrised CSR configuration master. Converts a simple req/ack config port into single-beat AXI4 accesses via an internal slave NAP (CSR access enabled).

---
 rtl/axi_nap_csr_master_ext.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_nap_csr_master_ext.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_nap_csr_master_ext.sv
// CSR configuration master: turns a req/ack config port into single-beat AXI4 accesses
// on a NAP, with byte strobes, response reporting, timeout with safe drain and stale discard.
module axi_nap_csr_master_ext #(
    parameter int          CFG_ADDR_WIDTH = 28,
    parameter int          CFG_DATA_WIDTH = 256,
    parameter logic [7:0]  CSR_ADDR_ID    = 8'h20,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        i_cfg_clk,
    input  logic                        i_cfg_reset_n,
    input  logic [5:0]                  i_cfg_tgt_id,
    input  logic                        i_cfg_wr_rdn,
    input  logic [CFG_ADDR_WIDTH-1:0]   i_cfg_addr,
    input  logic [CFG_DATA_WIDTH-1:0]   i_cfg_wdata,
    input  logic [CFG_DATA_WIDTH/8-1:0] i_cfg_wstrb,
    input  logic                        i_cfg_req,
    output logic [CFG_DATA_WIDTH-1:0]   o_cfg_rdata,
    output logic                        o_cfg_ack,
    output logic [2:0]                  o_cfg_resp,
    output logic                        o_cfg_busy,
    output logic                        o_cfg_stale,
    output logic                        o_awvalid,
    input  logic                        i_awready,
    output logic [7:0]                  o_awid,
    output logic [41:0]                 o_awaddr,
    output logic [7:0]                  o_awlen,
    output logic [2:0]                  o_awsize,
    output logic [1:0]                  o_awburst,
    output logic                        o_awlock,
    output logic [3:0]                  o_awcache,
    output logic [2:0]                  o_awprot,
    output logic [3:0]                  o_awqos,
    output logic [3:0]                  o_awregion,
    output logic                        o_wvalid,
    input  logic                        i_wready,
    output logic [255:0]                o_wdata,
    output logic [31:0]                 o_wstrb,
    output logic                        o_wlast,
    input  logic                        i_bvalid,
    output logic                        o_bready,
    input  logic [7:0]                  i_bid,
    input  logic [1:0]                  i_bresp,
    output logic                        o_arvalid,
    input  logic                        i_arready,
    output logic [7:0]                  o_arid,
    output logic [41:0]                 o_araddr,
    output logic [7:0]                  o_arlen,
    output logic [2:0]                  o_arsize,
    output logic [1:0]                  o_arburst,
    output logic                        o_arlock,
    output logic [3:0]                  o_arcache,
    output logic [2:0]                  o_arprot,
    output logic [3:0]                  o_arqos,
    output logic [3:0]                  o_arregion,
    input  logic                        i_rvalid,
    output logic                        o_rready,
    input  logic [7:0]                  i_rid,
    input  logic [255:0]                i_rdata,
    input  logic [1:0]                  i_rresp
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWrite   = 3'd1;
    localparam logic [2:0] StRead    = 3'd2;
    localparam logic [2:0] StDrain   = 3'd3;
    localparam logic [2:0] StWaitReq = 3'd4;

    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]                state_q, state_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      ready_q, ready_d;
    logic [7:0]                awid_q, awid_d;
    logic [7:0]                arid_q, arid_d;
    logic [41:0]               addr_q, addr_d;
    logic [255:0]              wdata_q, wdata_d;
    logic [31:0]               wstrb_q, wstrb_d;
    logic [31:0]               tmo_q, tmo_d;
    logic                      ack_q, ack_d;
    logic [2:0]                resp_q, resp_d;
    logic [CFG_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      stale_q, stale_d;

    logic       b_hs, r_hs, b_match, r_match, tmo_hit, valid_left;
    logic [2:0] exit_state;
    logic       unused_rdata;

    // Upper NAP data lanes are unused when the config width is narrower than the NAP.
    assign unused_rdata = ^i_rdata;

    always_comb begin
        state_d   = state_q;
        awid_d    = awid_q;
        arid_d    = arid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        tmo_d     = tmo_q;
        ack_d     = 1'b0;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        stale_d   = stale_q;
        ready_d   = 1'b1;
        awvalid_d = awvalid_q && !i_awready;
        wvalid_d  = wvalid_q && !i_wready;
        arvalid_d = arvalid_q && !i_arready;

        b_hs    = i_bvalid && ready_q;
        r_hs    = i_rvalid && ready_q;
        b_match = b_hs && (state_q == StWrite) && (i_bid == awid_q);
        r_match = r_hs && (state_q == StRead) && (i_rid == arid_q);
        if ((b_hs && !b_match) || (r_hs && !r_match)) begin
            stale_d = 1'b1;
        end

        tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_q == TmoLast);
        valid_left = awvalid_d || wvalid_d || arvalid_d;
        exit_state = valid_left ? StDrain : (i_cfg_req ? StWaitReq : StIdle);

        case (state_q)
            StIdle: begin
                if (i_cfg_req) begin
                    tmo_d  = '0;
                    addr_d = {CSR_ADDR_ID, i_cfg_tgt_id, 28'(i_cfg_addr)};
                    if (i_cfg_wr_rdn) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awid_d    = awid_q + 8'd1;
                        wdata_d   = 256'(i_cfg_wdata);
                        wstrb_d   = 32'(i_cfg_wstrb);
                        state_d   = StWrite;
                    end else begin
                        arvalid_d = 1'b1;
                        arid_d    = arid_q + 8'd1;
                        state_d   = StRead;
                    end
                end
            end
            StWrite: begin
                tmo_d = tmo_q + 32'd1;
                if (b_match) begin
                    ack_d   = 1'b1;
                    resp_d  = {1'b0, i_bresp};
                    state_d = exit_state;
                end else if (tmo_hit) begin
                    ack_d   = 1'b1;
                    resp_d  = 3'b100;
                    state_d = exit_state;
                end
            end
            StRead: begin
                tmo_d = tmo_q + 32'd1;
                if (r_match) begin
                    ack_d   = 1'b1;
                    resp_d  = {1'b0, i_rresp};
                    rdata_d = i_rdata[CFG_DATA_WIDTH-1:0];
                    state_d = exit_state;
                end else if (tmo_hit) begin
                    ack_d   = 1'b1;
                    resp_d  = 3'b100;
                    state_d = exit_state;
                end
            end
            StDrain: begin
                // Valids stay up until accepted; requests wait until the bus is clean.
                if (!valid_left) begin
                    state_d = i_cfg_req ? StWaitReq : StIdle;
                end
            end
            StWaitReq: begin
                if (!i_cfg_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_cfg_clk or negedge i_cfg_reset_n) begin
        if (!i_cfg_reset_n) begin
            state_q   <= StIdle;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            ready_q   <= 1'b0;
            awid_q    <= '0;
            arid_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            tmo_q     <= '0;
            ack_q     <= 1'b0;
            resp_q    <= '0;
            rdata_q   <= '0;
            stale_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            ready_q   <= ready_d;
            awid_q    <= awid_d;
            arid_q    <= arid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            tmo_q     <= tmo_d;
            ack_q     <= ack_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            stale_q   <= stale_d;
        end
    end

    assign o_cfg_rdata = rdata_q;
    assign o_cfg_ack   = ack_q;
    assign o_cfg_resp  = resp_q;
    assign o_cfg_busy  = (state_q != StIdle);
    assign o_cfg_stale = stale_q;

    assign o_awvalid  = awvalid_q;
    assign o_awid     = awid_q;
    assign o_awaddr   = addr_q;
    assign o_awlen    = 8'h00;
    assign o_awsize   = 3'h5;
    assign o_awburst  = 2'b01;
    assign o_awlock   = 1'b0;
    assign o_awcache  = 4'h0;
    assign o_awprot   = 3'b010;
    assign o_awqos    = 4'h0;
    assign o_awregion = 4'h0;

    assign o_wvalid = wvalid_q;
    assign o_wdata  = wdata_q;
    assign o_wstrb  = wstrb_q;
    assign o_wlast  = 1'b1;
    assign o_bready = ready_q;

    assign o_arvalid  = arvalid_q;
    assign o_arid     = arid_q;
    assign o_araddr   = addr_q;
    assign o_arlen    = 8'h00;
    assign o_arsize   = 3'h5;
    assign o_arburst  = 2'b01;
    assign o_arlock   = 1'b0;
    assign o_arcache  = 4'h0;
    assign o_arprot   = 3'b010;
    assign o_arqos    = 4'h0;
    assign o_arregion = 4'h0;
    assign o_rready   = ready_q;

endmodule

// File: tb/tb_axi_nap_csr_master_ext.sv
// Bench for axi_nap_csr_master_ext: NAP slave model, directed vector table, hand-written
// corner sequences (timeout/stale, held request, mid-access reset) and a randomized phase.
module tb_axi_nap_csr_master_ext;
    localparam int AW = 28;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]    i_cfg_tgt_id = '0;
    logic          i_cfg_wr_rdn = 1'b0;
    logic [AW-1:0] i_cfg_addr = '0;
    logic [DW-1:0] i_cfg_wdata = '0;
    logic [3:0]    i_cfg_wstrb = '0;
    logic          i_cfg_req = 1'b0;
    logic [DW-1:0] o_cfg_rdata;
    logic          o_cfg_ack, o_cfg_busy, o_cfg_stale;
    logic [2:0]    o_cfg_resp;
    logic          o_awvalid, i_awready, o_awlock, o_wvalid, i_wready, o_wlast;
    logic [7:0]    o_awid, o_awlen, o_arid, o_arlen, i_bid, i_rid;
    logic [41:0]   o_awaddr, o_araddr;
    logic [2:0]    o_awsize, o_awprot, o_arsize, o_arprot;
    logic [1:0]    o_awburst, o_arburst, i_bresp, i_rresp;
    logic [3:0]    o_awcache, o_awqos, o_awregion, o_arcache, o_arqos, o_arregion;
    logic [255:0]  o_wdata, i_rdata;
    logic [31:0]   o_wstrb;
    logic          i_bvalid, o_bready, o_arvalid, i_arready, o_arlock, i_rvalid, o_rready;

    axi_nap_csr_master_ext #(
        .CFG_ADDR_WIDTH(AW), .CFG_DATA_WIDTH(DW), .CSR_ADDR_ID(8'h20), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_cfg_clk(clk), .i_cfg_reset_n(rst_n), .i_cfg_tgt_id(i_cfg_tgt_id),
        .i_cfg_wr_rdn(i_cfg_wr_rdn), .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata),
        .i_cfg_wstrb(i_cfg_wstrb), .i_cfg_req(i_cfg_req), .o_cfg_rdata(o_cfg_rdata),
        .o_cfg_ack(o_cfg_ack), .o_cfg_resp(o_cfg_resp), .o_cfg_busy(o_cfg_busy),
        .o_cfg_stale(o_cfg_stale),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awid(o_awid), .o_awaddr(o_awaddr),
        .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst), .o_awlock(o_awlock),
        .o_awcache(o_awcache), .o_awprot(o_awprot), .o_awqos(o_awqos),
        .o_awregion(o_awregion),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .o_wlast(o_wlast),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bid(i_bid), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_arid(o_arid), .o_araddr(o_araddr),
        .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arlock(o_arlock),
        .o_arcache(o_arcache), .o_arprot(o_arprot), .o_arqos(o_arqos),
        .o_arregion(o_arregion),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rid(i_rid), .i_rdata(i_rdata),
        .i_rresp(i_rresp)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_count = 0;
    int          ar_count = 0;
    logic [7:0]  exp_awid = '0;
    logic [7:0]  exp_arid = '0;
    logic [41:0] exp_addr = '0;
    bit          stall_r = 0;
    bit          ar_block = 0;
    bit          slave_err = 0;
    logic [31:0] slv_mem [logic [41:0]];
    logic [31:0] ref_mem [logic [33:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // Reference model: a word-per-{target,offset} store with byte-enable merge.
    function automatic logic [31:0] ref_read(input logic [33:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    task automatic ref_write(input logic [33:0] k, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = ref_read(k);
        for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[k] = w;
    endtask

    initial begin : ack_counter
        forever begin
            @(negedge clk);
            if (o_cfg_ack) ack_count++;
        end
    end

    initial begin : nap_slave
        logic aw_hs, w_hs, ar_hs, b_hs, r_hs, s_wlast;
        logic [41:0] s_awaddr, s_araddr, wr_addr, rd_addr;
        logic [7:0] s_awid, s_arid, b_id, r_id;
        logic [255:0] s_wdata;
        logic [31:0] s_wstrb, wr_data, cur;
        logic [28:0] s_aw_attr, s_ar_attr;
        logic [28:0] attr_want;
        logic [3:0] wr_strb;
        logic aw_got, w_got, ar_got, b_pend, b_err, r_err;
        int b_dly, r_dly;
        attr_want = {8'h00, 3'h5, 2'b01, 1'b0, 4'h0, 3'b010, 4'h0, 4'h0};
        aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0; b_err = 0; r_err = 0;
        b_dly = 0; r_dly = 0; b_id = '0; r_id = '0; wr_addr = '0; rd_addr = '0;
        wr_data = '0; wr_strb = '0;
        i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
        i_bid = '0; i_bresp = '0; i_rid = '0; i_rresp = '0; i_rdata = '0;
        forever begin
            @(negedge clk);
            aw_hs = o_awvalid && i_awready;
            w_hs  = o_wvalid && i_wready;
            ar_hs = o_arvalid && i_arready;
            b_hs  = i_bvalid && o_bready;
            r_hs  = i_rvalid && o_rready;
            s_awaddr = o_awaddr; s_awid = o_awid; s_araddr = o_araddr; s_arid = o_arid;
            s_wdata = o_wdata; s_wstrb = o_wstrb; s_wlast = o_wlast;
            s_aw_attr = {o_awlen, o_awsize, o_awburst, o_awlock, o_awcache, o_awprot,
                         o_awqos, o_awregion};
            s_ar_attr = {o_arlen, o_arsize, o_arburst, o_arlock, o_arcache, o_arprot,
                         o_arqos, o_arregion};
            @(posedge clk);
            #1;
            if (!rst_n) begin
                aw_got = 0; w_got = 0; ar_got = 0; b_pend = 0;
                i_bvalid = 0; i_rvalid = 0; i_awready = 0; i_wready = 0; i_arready = 0;
            end else begin
                if (aw_hs) begin
                    chk("awid", {56'h0, s_awid}, {56'h0, exp_awid});
                    chk("awaddr", {22'h0, s_awaddr}, {22'h0, exp_addr});
                    chk("aw_attr", {35'h0, s_aw_attr}, {35'h0, attr_want});
                    aw_got = 1; wr_addr = s_awaddr; b_id = s_awid;
                end
                if (w_hs) begin
                    chk("wdata_hi_zero", {63'h0, |s_wdata[255:32]}, 64'h0);
                    chk("wstrb_hi_zero", {36'h0, s_wstrb[31:4]}, 64'h0);
                    chk("wlast", {63'h0, s_wlast}, 64'h1);
                    w_got = 1; wr_data = s_wdata[31:0]; wr_strb = s_wstrb[3:0];
                end
                if (ar_hs) begin
                    ar_count++;
                    chk("arid", {56'h0, s_arid}, {56'h0, exp_arid});
                    chk("araddr", {22'h0, s_araddr}, {22'h0, exp_addr});
                    chk("ar_attr", {35'h0, s_ar_attr}, {35'h0, attr_want});
                    ar_got = 1; rd_addr = s_araddr; r_id = s_arid;
                    r_dly = $urandom_range(0, 2); r_err = slave_err;
                end
                if (b_hs) i_bvalid = 0;
                if (r_hs) i_rvalid = 0;
                if (aw_got && w_got && !b_pend && !i_bvalid) begin
                    b_pend = 1; b_err = slave_err; b_dly = $urandom_range(0, 2);
                    aw_got = 0; w_got = 0;
                    if (!b_err) begin
                        cur = slv_mem.exists(wr_addr) ? slv_mem[wr_addr] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (wr_strb[b]) cur[8*b +: 8] = wr_data[8*b +: 8];
                        slv_mem[wr_addr] = cur;
                    end
                end
                if (b_pend && !i_bvalid) begin
                    if (b_dly == 0) begin
                        i_bvalid = 1; i_bid = b_id; i_bresp = b_err ? 2'b10 : 2'b00;
                        b_pend = 0;
                    end else b_dly--;
                end
                if (ar_got && !stall_r && !i_rvalid) begin
                    if (r_dly == 0) begin
                        i_rvalid = 1; i_rid = r_id; i_rresp = r_err ? 2'b10 : 2'b00;
                        i_rdata = r_err ? 256'hDEAD_BEEF :
                                  256'(slv_mem.exists(rd_addr) ? slv_mem[rd_addr] : 32'h0);
                        ar_got = 0;
                    end else r_dly--;
                end
                i_awready = ($urandom_range(0, 3) != 0);
                i_wready  = ($urandom_range(0, 3) != 0);
                i_arready = ar_block ? 1'b0 : ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic cfg_access(input bit wr, input logic [5:0] tgt, input logic [27:0] addr,
                              input logic [31:0] wd, input logic [3:0] ws, input int hold,
                              output logic [2:0] resp, output logic [31:0] rd,
                              output int lat);
        int acks0;
        bit got;
        @(posedge clk);
        #1;
        i_cfg_wr_rdn = wr; i_cfg_tgt_id = tgt; i_cfg_addr = addr;
        i_cfg_wdata = wd; i_cfg_wstrb = ws; i_cfg_req = 1'b1;
        exp_addr = {8'h20, tgt, addr};
        if (wr) exp_awid = exp_awid + 8'd1;
        else exp_arid = exp_arid + 8'd1;
        acks0 = ack_count;
        @(posedge clk);
        got = 0; lat = 0; resp = 'x; rd = 'x;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (o_cfg_ack) begin
                got = 1; resp = o_cfg_resp; rd = o_cfg_rdata;
            end else lat++;
        end
        chk("ack_seen", {63'h0, got}, 64'h1);
        @(negedge clk);
        chk("ack_single_pulse", {63'h0, o_cfg_ack}, 64'h0);
        for (int i = 1; i < hold; i++) @(negedge clk);
        @(posedge clk);
        #1;
        i_cfg_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_req_drop", {63'h0, o_cfg_busy}, 64'h0);
        chk("one_ack_per_access", 64'(ack_count - acks0), 64'h1);
    endtask

    typedef struct {
        bit          wr;
        logic [5:0]  tgt;
        logic [27:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          err;
        logic [2:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin : main
        vec_t vecs[9];
        logic [2:0]  resp;
        logic [31:0] rd, prev_rd;
        int          lat, ar0, acks0;
        bit          wr, err;
        logic [5:0]  tgt;
        logic [27:0] addr;
        logic [31:0] wd, want;
        logic [3:0]  ws;

        vecs[0] = '{1'b1, 6'h05, 28'h10, 32'hA5A5_0001, 4'hF, 1'b0, 3'b000, 32'h0};
        vecs[1] = '{1'b0, 6'h05, 28'h10, 32'h0, 4'h0, 1'b0, 3'b000, 32'hA5A5_0001};
        vecs[2] = '{1'b1, 6'h05, 28'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, 3'b000, 32'h0};
        vecs[3] = '{1'b1, 6'h05, 28'h20, 32'h1234_5678, 4'b0011, 1'b0, 3'b000, 32'h0};
        vecs[4] = '{1'b0, 6'h05, 28'h20, 32'h0, 4'h0, 1'b0, 3'b000, 32'hFFFF_5678};
        vecs[5] = '{1'b1, 6'h3F, 28'hFFF_FFFF, 32'h00C0_FFEE, 4'b1100, 1'b0, 3'b000, 32'h0};
        vecs[6] = '{1'b0, 6'h3F, 28'hFFF_FFFF, 32'h0, 4'h0, 1'b0, 3'b000, 32'h00C0_0000};
        vecs[7] = '{1'b1, 6'h05, 28'h10, 32'h0, 4'hF, 1'b1, 3'b010, 32'h0};
        vecs[8] = '{1'b0, 6'h05, 28'h10, 32'h0, 4'h0, 1'b0, 3'b000, 32'hA5A5_0001};

        #1 rst_n = 1'b0;
        #2;
        chk("rst_ack", {63'h0, o_cfg_ack}, 64'h0);
        chk("rst_busy", {63'h0, o_cfg_busy}, 64'h0);
        chk("rst_stale", {63'h0, o_cfg_stale}, 64'h0);
        chk("rst_resp_rdata", {29'h0, o_cfg_resp, o_cfg_rdata}, 64'h0);
        chk("rst_valids_readies", {59'h0, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready},
            64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("readies_high_after_reset", {62'h0, o_bready, o_rready}, 64'h3);

        foreach (vecs[i]) begin
            slave_err = vecs[i].err;
            cfg_access(vecs[i].wr, vecs[i].tgt, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                       1, resp, rd, lat);
            slave_err = 0;
            chk($sformatf("vec%0d_resp", i), {61'h0, resp}, {61'h0, vecs[i].exp_resp});
            if (!vecs[i].wr)
                chk($sformatf("vec%0d_rdata", i), {32'h0, rd}, {32'h0, vecs[i].exp_rdata});
            if (vecs[i].wr && !vecs[i].err)
                ref_write({vecs[i].tgt, vecs[i].addr}, vecs[i].wdata, vecs[i].wstrb);
        end

        // SLVERR read with the request held for 5 cycles after the ack.
        slave_err = 1;
        ar0 = ar_count;
        cfg_access(1'b0, 6'h05, 28'h20, 32'h0, 4'h0, 5, resp, rd, lat);
        slave_err = 0;
        chk("slverr_resp", {61'h0, resp}, 64'h2);
        chk("slverr_rdata", {32'h0, rd}, 64'hDEAD_BEEF);
        chk("held_req_single_ar", 64'(ar_count - ar0), 64'h1);

        // Stalled read: timeout, then the late response must be discarded as stale.
        stall_r = 1;
        prev_rd = o_cfg_rdata;
        cfg_access(1'b0, 6'h05, 28'h10, 32'h0, 4'h0, 1, resp, rd, lat);
        chk("timeout_resp", {61'h0, resp}, 64'h4);
        chk("timeout_latency", 64'(lat), 64'd16);
        chk("timeout_rdata_kept", {32'h0, rd}, {32'h0, prev_rd});
        acks0 = ack_count;
        stall_r = 0;
        repeat (10) @(negedge clk);
        chk("stale_set", {63'h0, o_cfg_stale}, 64'h1);
        chk("stale_no_ack", 64'(ack_count - acks0), 64'h0);
        cfg_access(1'b0, 6'h05, 28'h10, 32'h0, 4'h0, 1, resp, rd, lat);
        chk("after_timeout_resp", {61'h0, resp}, 64'h0);
        chk("after_timeout_rdata", {32'h0, rd}, 64'hA5A5_0001);

        // Reset while a read is waiting on arready.
        ar_block = 1;
        @(posedge clk);
        #1;
        i_cfg_wr_rdn = 1'b0; i_cfg_tgt_id = 6'h05; i_cfg_addr = 28'h10; i_cfg_req = 1'b1;
        exp_arid = exp_arid + 8'd1;
        exp_addr = {8'h20, 6'h05, 28'h10};
        @(posedge clk);
        @(negedge clk);
        chk("arvalid_before_reset", {63'h0, o_arvalid}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_valids", {61'h0, o_awvalid, o_wvalid, o_arvalid}, 64'h0);
        chk("reset_mid_cfg", {27'h0, o_cfg_ack, o_cfg_busy, o_cfg_stale, o_cfg_resp,
                              o_cfg_rdata}, 64'h0);
        chk("reset_mid_readies", {62'h0, o_bready, o_rready}, 64'h0);
        i_cfg_req = 1'b0;
        exp_awid = '0;
        exp_arid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ar_block = 0;
        cfg_access(1'b1, 6'h05, 28'h30, 32'hCAFE_F00D, 4'hF, 1, resp, rd, lat);
        chk("post_reset_write_resp", {61'h0, resp}, 64'h0);
        ref_write({6'h05, 28'h30}, 32'hCAFE_F00D, 4'hF);

        // Randomized accesses against the reference model; long enough for ID wrap.
        for (int n = 0; n < 600; n++) begin
            wr   = $urandom_range(0, 1) != 0;
            tgt  = ($urandom_range(0, 1) != 0) ? 6'h01 : 6'h02;
            addr = 28'($urandom_range(0, 3));
            wd   = $urandom;
            ws   = 4'($urandom_range(0, 15));
            err  = $urandom_range(0, 7) == 0;
            slave_err = err;
            cfg_access(wr, tgt, addr, wd, ws, 1, resp, rd, lat);
            slave_err = 0;
            chk("rand_resp", {61'h0, resp}, err ? 64'h2 : 64'h0);
            if (!wr) begin
                want = err ? 32'hDEAD_BEEF : ref_read({tgt, addr});
                chk("rand_rdata", {32'h0, rd}, {32'h0, want});
            end else if (!err) begin
                ref_write({tgt, addr}, wd, ws);
            end
        end
        chk("no_stale_in_random", {63'h0, o_cfg_stale}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
        $fatal(1, "watchdog expired");
    end

endmodule
